// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state type, default widths and address field helpers
package cache_pkg;
  localparam int ADDR_W_DEF  = 32;
  localparam int INDEX_W_DEF = 10;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_MAX  = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WRITEBACK,
    ST_ALLOCATE
  } state_e;

  function automatic logic [ADDR_W_MAX-1:0] addr_tag(input logic [ADDR_W_MAX-1:0] addr,
                                                      input int index_w);
    return addr >> (index_w + 2);
  endfunction

  function automatic logic [ADDR_W_MAX-1:0] addr_index(input logic [ADDR_W_MAX-1:0] addr,
                                                        input int index_w);
    return (addr >> 2) & ((ADDR_W_MAX'(1) << index_w) - ADDR_W_MAX'(1));
  endfunction
endpackage

// File: rtl/cache_tag_store.sv
// rtl/cache_tag_store.sv - tag, valid and dirty arrays with one write port and a combinational lookup
module cache_tag_store #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_dirty,
  input  logic [INDEX_W-1:0] lk_index,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               lk_hit,
  output logic               lk_dirty,
  output logic [TAG_W-1:0]   lk_stored_tag
);
  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0] tag_q [LINES];
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;

  // every write (fill or write hit) leaves the line valid
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      valid_d[wr_index] = 1'b1;
      dirty_d[wr_index] = wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) tag_q[wr_index] <= wr_tag;
  end

  assign lk_stored_tag = tag_q[lk_index];
  assign lk_hit        = valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
  assign lk_dirty      = valid_q[lk_index] && dirty_q[lk_index];
endmodule

// File: rtl/dm_cache_sequencer.sv
// rtl/dm_cache_sequencer.sv - direct-mapped write-back cache controller with miss sequencing and hit/miss stats
module dm_cache_sequencer
  import cache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = ADDR_W - INDEX_W - 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int LINES = 1 << INDEX_W;

  state_e            state_q, state_d;
  logic              first_q, first_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d;
  logic [CNT_W-1:0]  miss_count_q, miss_count_d;

  logic [DATA_W-1:0] data_q [LINES];
  logic              data_we;
  logic [DATA_W-1:0] data_wval;
  logic              tag_we, tag_wdirty;

  logic [ADDR_W_MAX-1:0] addr_ext, tag_full, index_full;
  logic [TAG_W-1:0]      req_tag, lk_stored_tag;
  logic [INDEX_W-1:0]    req_index;
  logic                  lk_hit, lk_dirty;
  logic                  unused_addr_bits;

  assign addr_ext         = ADDR_W_MAX'(addr_q);
  assign tag_full         = addr_tag(addr_ext, INDEX_W);
  assign index_full       = addr_index(addr_ext, INDEX_W);
  assign req_tag          = tag_full[TAG_W-1:0];
  assign req_index        = index_full[INDEX_W-1:0];
  assign unused_addr_bits = ^{tag_full[ADDR_W_MAX-1:TAG_W], index_full[ADDR_W_MAX-1:INDEX_W]};

  cache_tag_store #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_tag_store (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (tag_we),
    .wr_index     (req_index),
    .wr_tag       (req_tag),
    .wr_dirty     (tag_wdirty),
    .lk_index     (req_index),
    .lk_tag       (req_tag),
    .lk_hit       (lk_hit),
    .lk_dirty     (lk_dirty),
    .lk_stored_tag(lk_stored_tag)
  );

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_ready_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    data_we      = 1'b0;
    data_wval    = wdata_q;
    tag_we       = 1'b0;
    tag_wdirty   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          first_d = 1'b1;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        first_d = 1'b0;
        // only the compare right after acceptance is counted; the post-fill re-compare is not
        if (first_q) begin
          if (lk_hit) begin
            if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_W'(1);
          end else if (miss_count_q != '1) begin
            miss_count_d = miss_count_q + CNT_W'(1);
          end
        end
        if (lk_hit) begin
          cpu_ready_d = 1'b1;
          state_d     = ST_IDLE;
          if (we_q) begin
            data_we    = 1'b1;
            tag_we     = 1'b1;
            tag_wdirty = 1'b1;
          end else begin
            cpu_rdata_d = data_q[req_index];
          end
        end else if (lk_dirty) begin
          state_d     = ST_WRITEBACK;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {lk_stored_tag, req_index, 2'b00};
          mem_wdata_d = data_q[req_index];
        end else begin
          state_d    = ST_ALLOCATE;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_index, 2'b00};
        end
      end
      ST_WRITEBACK: begin
        if (mem_ack) begin
          state_d    = ST_ALLOCATE;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_index, 2'b00};
        end
      end
      ST_ALLOCATE: begin
        if (mem_ack) begin
          state_d   = ST_COMPARE;
          mem_req_d = 1'b0;
          data_we   = 1'b1;
          data_wval = mem_rdata;
          tag_we    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      first_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we && !rst) data_q[req_index] <= data_wval;
  end

  assign cpu_ready  = cpu_ready_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
endmodule

// File: tb/tb_dm_cache_sequencer.sv
// tb/tb_dm_cache_sequencer.sv - randomized bench comparing the cache against a flat-memory reference
module tb_dm_cache_sequencer;
  localparam int IW    = 4;
  localparam int LINES = 1 << IW;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  dm_cache_sequencer #(
    .ADDR_W (32),
    .INDEX_W(IW),
    .DATA_W (32),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference: line bookkeeping plus a flat view of memory as the CPU should see it
  logic        m_valid [LINES];
  logic        m_dirty [LINES];
  logic [31:0] m_tag   [LINES];
  int          m_hits, m_misses;
  logic [31:0] flat    [logic [31:0]];
  logic [31:0] mainmem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mainmem.exists(a)) return mainmem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] flat_val(input logic [31:0] a);
    if (flat.exists(a)) return flat[a];
    return mem_val(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    m_hits   = 0;
    m_misses = 0;
    flat.delete();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_dly);
    logic [31:0] word, tg, victim, cur_addr, cur_data;
    logic        hit, cur_we, done, in_txn;
    logic [31:0] q_addr[$], q_data[$];
    logic        q_we[$];
    int          idx, cyc, wait_cnt, ack_cyc, exp_lat;

    word = addr & ~32'h3;
    idx  = int'((addr >> 2) % LINES);
    tg   = addr >> (IW + 2);
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    if (!hit && m_valid[idx] && m_dirty[idx]) begin
      victim = (m_tag[idx] << (IW + 2)) | (32'(idx) << 2);
      q_we.push_back(1'b1); q_addr.push_back(victim); q_data.push_back(flat_val(victim));
    end
    if (!hit) begin
      q_we.push_back(1'b0); q_addr.push_back(word); q_data.push_back(32'h0);
    end

    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    cyc = 0; done = 1'b0; in_txn = 1'b0; ack_cyc = 0; wait_cnt = 0;
    cur_addr = '0; cur_data = '0; cur_we = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mem_ack) begin
        mem_ack = 1'b0;
        in_txn  = 1'b0;
      end
      if (cpu_ready) begin
        done = 1'b1;
      end else if (mem_req) begin
        if (!in_txn) begin
          chk("mem_txn_expected", 32'(q_addr.size() > 0), 32'd1);
          if (q_addr.size() > 0) begin
            cur_we = q_we.pop_front(); cur_addr = q_addr.pop_front(); cur_data = q_data.pop_front();
            in_txn = 1'b1; wait_cnt = 0;
          end
        end
        if (in_txn) begin
          chk("mem_we", 32'(mem_we), 32'(cur_we));
          chk("mem_addr", mem_addr, cur_addr);
          if (cur_we) chk("mem_wdata", mem_wdata, cur_data);
          if (wait_cnt == ack_dly) begin
            mem_ack = 1'b1;
            if (mem_we) mainmem[mem_addr] = mem_wdata;
            else mem_rdata = mem_val(mem_addr);
            ack_cyc = cyc;
          end
          wait_cnt++;
        end
      end
    end
    mem_ack = 1'b0;
    chk("ready_seen", 32'(done), 32'd1);
    exp_lat = hit ? 2 : ack_cyc + 2;
    chk("ready_latency", 32'(cyc), 32'(exp_lat));
    chk("txn_left", 32'(q_addr.size()), 32'd0);
    if (!we) chk("rdata", cpu_rdata, flat_val(word));
    cpu_req = 1'b0;

    if (hit) m_hits = (m_hits < CMAX) ? m_hits + 1 : CMAX;
    else m_misses = (m_misses < CMAX) ? m_misses + 1 : CMAX;
    m_dirty[idx] = hit ? (m_dirty[idx] | we) : we;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    if (we) flat[word] = wdata;

    @(negedge clk);
    chk("ready_pulse", 32'(cpu_ready), 32'd0);
    chk("hit_count", 32'(hit_count), 32'(m_hits));
    chk("miss_count", 32'(miss_count), 32'(m_misses));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, tg;
    int n, t;

    do_reset();
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);

    mainmem[32'h0000_1004] = 32'hDEAD_BEEF;
    cpu_access(1'b0, 32'h0000_1004, 32'h0, 0);
    chk("first_read_data", cpu_rdata, 32'hDEAD_BEEF);
    chk("first_read_miss", 32'(miss_count), 32'd1);

    cpu_access(1'b0, 32'h0000_1004, 32'h0, 0);
    chk("second_read_hit", 32'(hit_count), 32'd1);

    cpu_access(1'b1, 32'h0000_1004, 32'hCAFE_F00D, 0);
    cpu_access(1'b0, 32'h0010_1004, 32'h0, 2);
    chk("alias_writeback", mem_val(32'h0000_1004), 32'hCAFE_F00D);

    cpu_access(1'b0, 32'h0000_3010, 32'h0, 7);

    cpu_access(1'b1, 32'h0000_2008, 32'h1234_5678, 0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0010_2008;
    @(posedge clk);
    n = 0;
    while (!(mem_req && mem_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_wb_seen", 32'({mem_req, mem_we}), 32'd3);
    chk("rst_mid_wb_addr", mem_addr, 32'h0000_2008);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    chk("rst_mid_req_low", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_req_low", 32'(mem_req), 32'd0);
    chk("late_ack_no_ready", 32'(cpu_ready), 32'd0);
    chk("late_ack_addr", mem_addr, 32'd0);
    model_reset();
    cpu_access(1'b0, 32'h0000_2008, 32'h0, 1);
    chk("post_rst_miss", 32'(miss_count), 32'd1);

    for (int i = 0; i < 5; i++) cpu_access(1'b0, 32'h0000_2008, 32'h0, 0);
    chk("hit_saturate", 32'(hit_count), 32'd3);

    do_reset();
    for (int i = 0; i < 200; i++) begin
      t  = int'($urandom_range(0, 3));
      tg = (t == 3) ? 32'h03FF_FFFF : 32'(t);
      a  = (tg << (IW + 2)) | (32'($urandom_range(0, LINES - 1)) << 2) | 32'($urandom_range(0, 3));
      cpu_access(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dm_cache_sequencer.md
# dm_cache_sequencer

Sequencing controller for the direct-mapped, write-back, write-allocate cache, between the CPU request port and the main memory port. It owns the tag, valid, dirty and data arrays and performs the per-request tag compare. On a miss it runs a write-back and allocate sequence over a single-outstanding-request memory handshake. It also keeps saturating hit/miss statistics.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- INDEX_W, 10, line index width; 2^INDEX_W lines of one DATA_W word each
- DATA_W, 32, word width
- TAG_W, ADDR_W-INDEX_W-2 (20 at defaults), tag width; address bits [1:0] are ignored
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  request valid; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data; valid when cpu_ready=1 and the request was a read
- cpu_ready  out  1  one-cycle completion pulse
- mem_req  out  1  memory transaction valid
- mem_we  out  1  1 = write-back, 0 = line fetch
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] = 0
- mem_wdata  out  DATA_W  write-back data
- mem_rdata  in  DATA_W  fetch data; valid with mem_ack
- mem_ack  in  1  completes the outstanding transaction
- hit_count  out  CNT_W  saturating count of requests that hit on first compare
- miss_count  out  CNT_W  saturating count of requests that missed on first compare

## Operation
- Address split: tag = addr[ADDR_W-1:INDEX_W+2], index = addr[INDEX_W+1:2].
- IDLE: if cpu_req=1, latch we/addr/wdata, go COMPARE. Otherwise stay.
- COMPARE: hit = valid[index] and (tag[index] == latched tag).
  - Read hit: cpu_rdata = data[index], pulse cpu_ready, go IDLE.
  - Write hit: data[index] <= wdata, dirty <= 1, pulse cpu_ready, go IDLE.
  - Miss with line clean or invalid: go ALLOCATE.
  - Miss with line valid and dirty: go WRITEBACK.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr = {stored tag, index, 2'b00}, mem_wdata = data[index].
  - On mem_ack: go ALLOCATE.
- ALLOCATE: mem_req=1, mem_we=0, mem_addr = {latched tag, index, 2'b00}.
  - On mem_ack: data <= mem_rdata, tag <= latched tag, valid <= 1, dirty <= 0, go COMPARE. The re-compare hits and completes the request.
- Statistics:
  - Only the first COMPARE of each request counts.
  - A flag set on entry from IDLE and cleared on leaving COMPARE marks the first compare.
  - Counters saturate at 2^CNT_W-1; no wrap.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.

## Timing
- Reset values:
  - State IDLE; all valid and dirty bits 0.
  - cpu_ready=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hit_count=0, miss_count=0.
  - Tag and data arrays are not reset.
- Outputs are registered.
- Hit latency: request sampled at edge N; cpu_ready high during cycle N+1 to N+2.
- Clean miss: cpu_ready follows two cycles after the cycle in which mem_ack is sampled.
- Dirty miss: adds one full write-back transaction before the fetch.
- Memory handshake:
  - mem_req and the address/data stay stable until mem_ack is sampled.
  - mem_ack with mem_req=0 is ignored.
  - WRITEBACK to ALLOCATE keeps mem_req high and changes mem_we and mem_addr. The memory treats this as a new transaction.
- cpu_req outside IDLE is ignored. The CPU holds cpu_req until cpu_ready; a request held through the ready cycle is re-accepted in the following IDLE cycle.
- Reset mid-miss: transaction abandoned, mem_req low from the next cycle, a late mem_ack ignored, and no array update.
- Index aliasing: a write-back of tag A followed by a fetch of tag B at the same index must not corrupt the fetched line.

## Structure
- Package cache_pkg holds:
  - State enum.
  - ADDR_W, INDEX_W, DATA_W default constants.
  - Tag/index extraction functions.
- Sub-module cache_tag_store holds the tag, valid and dirty arrays. It has:
  - A synchronous write port.
  - A combinational lookup port returning the hit flag and the stored tag.
  - A synchronous clear-all on rst.
- The data array and FSM stay in dm_cache_sequencer.

## Test plan
- After reset, read 0x0000_1004: miss, ALLOCATE fetch of 0x0000_1004. With mem_rdata=0xDEADBEEF, expect cpu_rdata=0xDEADBEEF and miss_count=1.
- Read 0x0000_1004 again: cpu_ready one cycle after acceptance, no mem_req, hit_count=1.
- Write 0xCAFEF00D to 0x0000_1004 (hit). Then read 0x0010_1004, which has the same index and a different tag. Expect write-back of 0xCAFEF00D to 0x0000_1004, then a fetch of 0x0010_1004.
- Hold mem_ack low for 7 cycles during ALLOCATE: mem_req, mem_we and mem_addr stay stable, and cpu_ready stays 0.
- Assert rst during WRITEBACK, then ack one cycle later: mem_req=0, no state change, and a following read of the same address misses (valid cleared).
- Preload hit_count to saturation by forcing CNT_W=2 and issuing 5 hits: hit_count stays at 3.
